dcache_controller: RTL and testbench



---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_if.sv | 29 ++
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_controller.sv | 157 +++++++++++++++
 tb/tb_dcache_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the L1 data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_ALLOCATE,
        ST_REFILL
    } dcache_state_e;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_LINE_BITS  = 256;
    localparam int OFFSET_W       = $clog2(DEF_LINE_BITS / 8);
    localparam int INDEX_W        = $clog2(DEF_NUM_SETS);
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS_PER_LINE = DEF_LINE_BITS / DATA_W;

endpackage

// File: rtl/dcache_if.sv
// Line-granular request/acknowledge bus between the data cache (master) and off-chip memory (slave).
interface dcache_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport master (
        output mem_addr_o,
        output mem_data_o,
        output mem_enable_o,
        output mem_write_o,
        input  mem_data_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_enable_o,
        input  mem_write_o,
        output mem_data_i,
        output mem_ack_i
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, synchronous line or word write.
// Valid and dirty bits clear asynchronously on reset; tags and data are left as-is.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int IDX_W     = INDEX_W,
    parameter int TG_W      = TAG_W,
    parameter int WSEL_W    = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     index,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 line_we,
    input  logic [TG_W-1:0]      line_tag,
    input  logic [LINE_BITS-1:0] line_data,
    input  logic                 word_we,
    input  logic [WSEL_W-1:0]    word_sel,
    input  logic [DATA_W-1:0]    word_data
);
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TG_W-1:0]      tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

    // A refill installs a clean line; a store hit marks the resident line dirty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[index]  <= line_tag;
            data_q[index] <= line_data;
        end else if (word_we) begin
            data_q[index][word_sel*DATA_W +: DATA_W] <= word_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache; hits complete in the same cycle.
// Defining DCACHE_STATS_EN adds saturating hit_count_o / miss_count_o outputs.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o,
`endif
    dcache_if.master          mem
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS  = LINE_BITS / DATA_W;
    localparam int WSEL_W = $clog2(WORDS);

    dcache_state_e        state, next_state;
    logic [TG_W-1:0]      req_tag;
    logic [IDX_W-1:0]     req_index;
    logic [WSEL_W-1:0]    word_sel;
    logic                 request;
    logic                 hit;
    logic                 start_miss;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [DATA_W-1:0]    rd_word;
    logic                 line_we;
    logic                 word_we;
    logic                 unused_addr_bits;

    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TG_W];
    assign req_index        = cpu_addr_i[OFF_W +: IDX_W];
    assign word_sel         = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign request          = cpu_MemRead_i | cpu_MemWrite_i;
    assign rd_word          = rd_line[word_sel*DATA_W +: DATA_W];
    assign hit              = (state == ST_IDLE) && request && rd_valid && (rd_tag == req_tag);

    dcache_sram #(
        .NUM_SETS  (NUM_SETS),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .TG_W      (TG_W),
        .WSEL_W    (WSEL_W)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .index     (req_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (mem.mem_data_i),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .word_data (cpu_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // REFILL exists so the held request replays in IDLE against the freshly installed line.
    always_comb begin
        next_state       = state;
        cpu_stall_o      = 1'b0;
        cpu_data_o       = '0;
        mem.mem_enable_o = 1'b0;
        mem.mem_write_o  = 1'b0;
        mem.mem_addr_o   = '0;
        mem.mem_data_o   = '0;
        line_we          = 1'b0;
        word_we          = 1'b0;
        start_miss       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    word_we = cpu_MemWrite_i;
                    if (!cpu_MemWrite_i) begin
                        cpu_data_o = rd_word;
                    end
                end else if (request) begin
                    cpu_stall_o = 1'b1;
                    start_miss  = 1'b1;
                    next_state  = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                cpu_stall_o      = 1'b1;
                mem.mem_enable_o = 1'b1;
                mem.mem_write_o  = 1'b1;
                mem.mem_addr_o   = {rd_tag, req_index, {OFF_W{1'b0}}};
                mem.mem_data_o   = rd_line;
                if (mem.mem_ack_i) begin
                    next_state = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                cpu_stall_o      = 1'b1;
                mem.mem_enable_o = 1'b1;
                mem.mem_addr_o   = {req_tag, req_index, {OFF_W{1'b0}}};
                if (mem.mem_ack_i) begin
                    line_we    = 1'b1;
                    next_state = ST_REFILL;
                end
            end
            ST_REFILL: begin
                cpu_stall_o = 1'b1;
                next_state  = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic replay_q;

    // The first IDLE cycle after REFILL is the replay of an already-counted miss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            replay_q     <= 1'b0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            replay_q <= (state == ST_REFILL);
            if (hit && !replay_q && (hit_count_o != 32'hFFFF_FFFF)) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (start_miss && (miss_count_o != 32'hFFFF_FFFF)) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, reset/spurious-ack sequences,
// and randomized accesses checked against a flat-memory plus tag-array reference model.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int LB          = DEF_LINE_BITS;
    localparam int MEM_LINES   = 64;
    localparam int STALL_LIMIT = 300;
    localparam int NUM_RANDOM  = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        spurious_ack = 1'b0;
    int          lat_rd = 10;
    int          lat_wr = 10;
    int          checks = 0;
    int          errors = 0;

    dcache_if #(.LINE_BITS(LB)) mem_if ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_controller #(
        .NUM_SETS  (DEF_NUM_SETS),
        .LINE_BITS (LB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
`ifdef DCACHE_STATS_EN
        .hit_count_o    (hit_count),
        .miss_count_o   (miss_count),
`endif
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    // Behavioural memory: acks in the L-th cycle of an enabled request and logs each completed transfer.
    logic [LB-1:0] phys [MEM_LINES];
    logic          txn_wr   [1024];
    logic [31:0]   txn_addr [1024];
    logic [LB-1:0] txn_data [1024];
    int            txn_total = 0;
    int            mem_cnt = 0;
    int            cur_lat;
    logic          model_ack;

    assign cur_lat            = mem_if.mem_write_o ? lat_wr : lat_rd;
    assign model_ack          = mem_if.mem_enable_o && (mem_cnt == cur_lat - 1);
    assign mem_if.mem_ack_i   = model_ack | spurious_ack;
    assign mem_if.mem_data_i  = phys[mem_if.mem_addr_o[10:5]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h1234_5678;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    initial begin
        for (int i = 0; i < MEM_LINES; i++) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                phys[i][w*32 +: 32] = init_word(32'(i * 32 + w * 4));
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 0;
        end else begin
            if (model_ack) begin
                txn_wr[txn_total[9:0]]   <= mem_if.mem_write_o;
                txn_addr[txn_total[9:0]] <= mem_if.mem_addr_o;
                txn_data[txn_total[9:0]] <= mem_if.mem_data_o;
                if (mem_if.mem_write_o) begin
                    phys[mem_if.mem_addr_o[10:5]] <= mem_if.mem_data_o;
                end
                txn_total <= txn_total + 1;
            end
            mem_cnt <= (mem_if.mem_enable_o && !model_ack) ? mem_cnt + 1 : 0;
        end
    end

    task automatic check_output(input string name, input logic [LB-1:0] actual, input logic [LB-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one access at a negedge and hold it until the stall clears; returns stall length and load data.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                                  input logic wr, output int stall_cycles, output logic [31:0] rdata);
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_rd    = rd;
        cpu_wr    = wr;
        stall_cycles = 0;
        #1;
        while (cpu_stall === 1'b1 && stall_cycles < STALL_LIMIT) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        if (cpu_stall !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_timeout: stall=%b after %0d cycles, required 0", cpu_stall, stall_cycles);
        end
        rdata = cpu_rdata;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          exp_stall;
        logic [31:0] exp_data;
        int          exp_txns;
        logic [31:0] exp_first_addr;
        logic        exp_first_wr;
    } vec_t;

    vec_t                    vecs [4];
    int                      vec_base [4];
    logic [31:0]             ref_word [logic [31:0]];
    bit                      m_valid [DEF_NUM_SETS];
    bit                      m_dirty [DEF_NUM_SETS];
    logic [31:0]             m_tag   [DEF_NUM_SETS];

    // Architectural view of memory: last stored value, else what physical memory currently holds.
    function automatic logic [31:0] get_word(input logic [31:0] a);
        if (ref_word.exists(a)) return ref_word[a];
        return phys[a[10:5]][a[4:2]*32 +: 32];
    endfunction

    initial begin
        int          st;
        int          base;
        int          n;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          set;
        logic [31:0] tag;
        int          exp_stall;
        int          exp_n;
        logic [31:0] exp_data;
        logic [31:0] wb_addr;
        logic [31:0] line_addr;
        logic [LB-1:0] wb_line;
        int          kind;

        #2;
        check_output("reset_stall", LB'(cpu_stall), LB'(1'b0));
        check_output("reset_enable", LB'(mem_if.mem_enable_o), LB'(1'b0));
        check_output("reset_write", LB'(mem_if.mem_write_o), LB'(1'b0));
        check_output("reset_mem_addr", LB'(mem_if.mem_addr_o), LB'(0));
        check_output("reset_mem_data", mem_if.mem_data_o, LB'(0));
        check_output("reset_cpu_data", LB'(cpu_rdata), LB'(0));
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{32'h0000_0040, 32'h0, 1'b1, 1'b0, 12, 32'h1234_5678, 1, 32'h0000_0040, 1'b0};
        vecs[1] = '{32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 32'h0, 0, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_0044, 32'h0, 1'b1, 1'b0, 0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0};
        vecs[3] = '{32'h0000_0244, 32'h0, 1'b1, 1'b0, 22, init_word(32'h0000_0244), 2, 32'h0000_0040, 1'b1};

        for (int i = 0; i < 4; i++) begin
            base = txn_total;
            vec_base[i] = base;
            apply_stimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, st, rdata);
            check_output($sformatf("vec%0d_stall", i), LB'(st), LB'(vecs[i].exp_stall));
            check_output($sformatf("vec%0d_data", i), LB'(rdata), LB'(vecs[i].exp_data));
            check_output($sformatf("vec%0d_txns", i), LB'(txn_total - base), LB'(vecs[i].exp_txns));
            if (vecs[i].exp_txns > 0 && txn_total > base) begin
                check_output($sformatf("vec%0d_addr", i), LB'(txn_addr[base[9:0]]), LB'(vecs[i].exp_first_addr));
                check_output($sformatf("vec%0d_wr", i), LB'(txn_wr[base[9:0]]), LB'(vecs[i].exp_first_wr));
            end
        end

        base = vec_base[3];
        check_output("wb_word1", LB'(txn_data[base[9:0]][63:32]), LB'(32'hDEAD_BEEF));
        check_output("wb_word0", LB'(txn_data[base[9:0]][31:0]), LB'(32'h1234_5678));
        base = base + 1;
        check_output("refill_addr", LB'(txn_addr[base[9:0]]), LB'(32'h0000_0240));
        check_output("refill_wr", LB'(txn_wr[base[9:0]]), LB'(1'b0));

`ifdef DCACHE_STATS_EN
        #1;
        check_output("hit_count", LB'(hit_count), LB'(32'd2));
        check_output("miss_count", LB'(miss_count), LB'(32'd2));
`endif

        // Reset in the middle of a line fill must abandon the fill and invalidate every line.
        @(negedge clk);
        cpu_addr = 32'h0000_0080;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_output("alloc_enable", LB'(mem_if.mem_enable_o), LB'(1'b1));
        check_output("alloc_stall", LB'(cpu_stall), LB'(1'b1));
        rst    = 1'b1;
        cpu_rd = 1'b0;
        #1;
        check_output("rst_mid_enable", LB'(mem_if.mem_enable_o), LB'(1'b0));
        check_output("rst_mid_stall", LB'(cpu_stall), LB'(1'b0));
        check_output("rst_mid_addr", LB'(mem_if.mem_addr_o), LB'(0));
        @(negedge clk);
        rst = 1'b0;
        base = txn_total;
        apply_stimulus(32'h0000_0040, 32'h0, 1'b1, 1'b0, st, rdata);
        check_output("post_rst_stall", LB'(st), LB'(12));
        check_output("post_rst_data", LB'(rdata), LB'(32'h1234_5678));
        check_output("post_rst_txns", LB'(txn_total - base), LB'(1));
        apply_stimulus(32'h0000_0044, 32'h0, 1'b1, 1'b0, st, rdata);
        check_output("post_rst_wb_data", LB'(rdata), LB'(32'hDEAD_BEEF));
        check_output("post_rst_hit_stall", LB'(st), LB'(0));

        // Spurious ack in IDLE alongside a store carrying both MemRead and MemWrite.
        base = txn_total;
        @(negedge clk);
        spurious_ack = 1'b1;
        cpu_addr     = 32'h0000_0048;
        cpu_wdata    = 32'hCAFE_F00D;
        cpu_rd       = 1'b1;
        cpu_wr       = 1'b1;
        #1;
        check_output("both_stall", LB'(cpu_stall), LB'(1'b0));
        check_output("both_cpu_data", LB'(cpu_rdata), LB'(0));
        check_output("both_enable", LB'(mem_if.mem_enable_o), LB'(1'b0));
        @(negedge clk);
        spurious_ack = 1'b0;
        cpu_rd       = 1'b0;
        cpu_wr       = 1'b0;
        apply_stimulus(32'h0000_0048, 32'h0, 1'b1, 1'b0, st, rdata);
        check_output("both_load_data", LB'(rdata), LB'(32'hCAFE_F00D));
        check_output("both_load_stall", LB'(st), LB'(0));
        check_output("both_txns", LB'(txn_total - base), LB'(0));

        // Randomized phase starts from an empty cache so the model only needs current memory contents.
        @(negedge clk);
        rst    = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_word.delete();
        for (int s = 0; s < DEF_NUM_SETS; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = '0;
        end

        for (int k = 0; k < NUM_RANDOM; k++) begin
            addr  = (32'($urandom_range(0, 2)) << (OFFSET_W + INDEX_W))
                  | (32'($urandom_range(0, 3)) << OFFSET_W)
                  | (32'($urandom_range(0, 7)) << 2);
            wdata = $urandom;
            kind  = $urandom_range(0, 2);
            rd    = (kind != 1);
            wr    = (kind != 0);
            lat_rd = $urandom_range(1, 6);
            lat_wr = $urandom_range(1, 6);

            set       = int'(addr[OFFSET_W +: INDEX_W]);
            tag       = addr >> (OFFSET_W + INDEX_W);
            line_addr = {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            exp_stall = 0;
            exp_n     = 0;
            wb_addr   = '0;
            wb_line   = '0;
            if (!(m_valid[set] && m_tag[set] == tag)) begin
                exp_stall = 1 + lat_rd + 1;
                exp_n     = 1;
                if (m_valid[set] && m_dirty[set]) begin
                    exp_stall = exp_stall + lat_wr;
                    exp_n     = 2;
                    wb_addr   = (m_tag[set] << (OFFSET_W + INDEX_W)) | (32'(set) << OFFSET_W);
                    for (int w = 0; w < WORDS_PER_LINE; w++) begin
                        wb_line[w*32 +: 32] = get_word(wb_addr + 32'(w * 4));
                    end
                end
                m_valid[set] = 1'b1;
                m_tag[set]   = tag;
                m_dirty[set] = 1'b0;
            end
            exp_data = (rd && !wr) ? get_word(addr) : 32'h0;

            base = txn_total;
            apply_stimulus(addr, wdata, rd, wr, st, rdata);
            n = txn_total - base;
            check_output($sformatf("rnd%0d_stall", k), LB'(st), LB'(exp_stall));
            check_output($sformatf("rnd%0d_data", k), LB'(rdata), LB'(exp_data));
            check_output($sformatf("rnd%0d_txns", k), LB'(n), LB'(exp_n));
            if (n == exp_n && exp_n == 2) begin
                check_output($sformatf("rnd%0d_wb_addr", k), LB'(txn_addr[base[9:0]]), LB'(wb_addr));
                check_output($sformatf("rnd%0d_wb_wr", k), LB'(txn_wr[base[9:0]]), LB'(1'b1));
                check_output($sformatf("rnd%0d_wb_line", k), txn_data[base[9:0]], wb_line);
                base = base + 1;
            end
            if (n == exp_n && exp_n > 0) begin
                check_output($sformatf("rnd%0d_rd_addr", k), LB'(txn_addr[base[9:0]]), LB'(line_addr));
                check_output($sformatf("rnd%0d_rd_wr", k), LB'(txn_wr[base[9:0]]), LB'(1'b0));
            end

            if (wr) begin
                m_dirty[set]   = 1'b1;
                ref_word[addr] = wdata;
            end
        end

        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
